// File: rtl/mem_arbiter_if.sv
// Bundled client-side and memory-controller-side signals of the two-client memory arbiter.
// slave is the arbiter's view; master is the view of the clients and memory controller.
interface mem_arbiter_if;
    logic        c0_req, c1_req;
    logic        c0_we, c1_we;
    logic [15:0] c0_address, c1_address;
    logic [15:0] c0_data, c1_data;
    logic        c0_gnt, c1_gnt;
    logic        c0_rd_valid, c1_rd_valid;
    logic [15:0] c0_rd_data, c1_rd_data;
    logic [15:0] c0_rd_address, c1_rd_address;
    logic        c0_wr_ack, c1_wr_ack;

    logic [15:0] wr_address, wr_data;
    logic        wr_en;
    logic [15:0] rd_address;
    logic        rd_en;
    logic [15:0] wr_ret_address;
    logic        wr_ret_ack;
    logic [15:0] rd_ret_data, rd_ret_address;
    logic        rd_ret_ack;
    logic        err;

    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_address, c1_address, c0_data, c1_data,
        output c0_gnt, c1_gnt, c0_rd_valid, c1_rd_valid, c0_rd_data, c1_rd_data,
        output c0_rd_address, c1_rd_address, c0_wr_ack, c1_wr_ack,
        output wr_address, wr_data, wr_en, rd_address, rd_en,
        input  wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack,
        output err
    );

    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_address, c1_address, c0_data, c1_data,
        input  c0_gnt, c1_gnt, c0_rd_valid, c1_rd_valid, c0_rd_data, c1_rd_data,
        input  c0_rd_address, c1_rd_address, c0_wr_ack, c1_wr_ack,
        input  wr_address, wr_data, wr_en, rd_address, rd_en,
        output wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack,
        input  err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of a memory controller; per-type tag FIFOs
// route in-order read/write returns back to the issuing client.
module mem_arbiter #(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned PW = $clog2(OUTSTANDING);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(OUTSTANDING);

    typedef enum logic {PRIO_C0 = 1'b0, PRIO_C1 = 1'b1} prio_t;
    prio_t prio;

    logic [1:0]  req, we, elig, gnt;
    logic [15:0] addr [2];
    logic [15:0] data [2];
    logic        sel, rd_push, wr_push, rd_pop, wr_pop, rd_ok, wr_ok;

    logic [OUTSTANDING-1:0] rd_tags, wr_tags;
    logic [PW-1:0]          rd_wptr, rd_rptr, wr_wptr, wr_rptr;
    logic [CW-1:0]          rd_cnt, wr_cnt;
    logic                   rd_head, wr_head;

    assign req     = {bus.c1_req, bus.c0_req};
    assign we      = {bus.c1_we, bus.c0_we};
    assign addr[0] = bus.c0_address;
    assign addr[1] = bus.c1_address;
    assign data[0] = bus.c0_data;
    assign data[1] = bus.c1_data;
    assign rd_head = rd_tags[rd_rptr];
    assign wr_head = wr_tags[wr_rptr];

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        rd_pop  = bus.rd_ret_ack && (rd_cnt != '0);
        wr_pop  = bus.wr_ret_ack && (wr_cnt != '0);
        rd_ok   = (rd_cnt != FULL) || rd_pop;
        wr_ok   = (wr_cnt != FULL) || wr_pop;
        elig[0] = req[0] && (we[0] ? wr_ok : rd_ok);
        elig[1] = req[1] && (we[1] ? wr_ok : rd_ok);
        gnt     = '0;
        if (rst_n) begin
            if (prio == PRIO_C0) begin
                if (elig[0])      gnt = 2'b01;
                else if (elig[1]) gnt = 2'b10;
            end else begin
                if (elig[1])      gnt = 2'b10;
                else if (elig[0]) gnt = 2'b01;
            end
        end
        sel     = gnt[1];
        rd_push = (gnt != '0) && !we[sel];
        wr_push = (gnt != '0) && we[sel];
    end

    assign bus.c0_gnt = gnt[0];
    assign bus.c1_gnt = gnt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio              <= PRIO_C0;
            bus.rd_en         <= 1'b0;
            bus.wr_en         <= 1'b0;
            bus.rd_address    <= '0;
            bus.wr_address    <= '0;
            bus.wr_data       <= '0;
            rd_tags           <= '0;
            wr_tags           <= '0;
            rd_wptr           <= '0;
            rd_rptr           <= '0;
            wr_wptr           <= '0;
            wr_rptr           <= '0;
            rd_cnt            <= '0;
            wr_cnt            <= '0;
            bus.c0_rd_valid   <= 1'b0;
            bus.c1_rd_valid   <= 1'b0;
            bus.c0_rd_data    <= '0;
            bus.c1_rd_data    <= '0;
            bus.c0_rd_address <= '0;
            bus.c1_rd_address <= '0;
            bus.c0_wr_ack     <= 1'b0;
            bus.c1_wr_ack     <= 1'b0;
            bus.err           <= 1'b0;
        end else begin
            if (gnt[0])      prio <= PRIO_C1;
            else if (gnt[1]) prio <= PRIO_C0;

            bus.rd_en <= rd_push;
            bus.wr_en <= wr_push;
            if (rd_push) bus.rd_address <= addr[sel];
            if (wr_push) begin
                bus.wr_address <= addr[sel];
                bus.wr_data    <= data[sel];
            end

            if (rd_push) begin
                rd_tags[rd_wptr] <= sel;
                rd_wptr          <= rd_wptr + 1'b1;
            end
            if (rd_pop) rd_rptr <= rd_rptr + 1'b1;
            case ({rd_push, rd_pop})
                2'b10:   rd_cnt <= rd_cnt + 1'b1;
                2'b01:   rd_cnt <= rd_cnt - 1'b1;
                default: rd_cnt <= rd_cnt;
            endcase

            if (wr_push) begin
                wr_tags[wr_wptr] <= sel;
                wr_wptr          <= wr_wptr + 1'b1;
            end
            if (wr_pop) wr_rptr <= wr_rptr + 1'b1;
            case ({wr_push, wr_pop})
                2'b10:   wr_cnt <= wr_cnt + 1'b1;
                2'b01:   wr_cnt <= wr_cnt - 1'b1;
                default: wr_cnt <= wr_cnt;
            endcase

            bus.c0_rd_valid <= rd_pop && !rd_head;
            bus.c1_rd_valid <= rd_pop && rd_head;
            if (rd_pop && !rd_head) begin
                bus.c0_rd_data    <= bus.rd_ret_data;
                bus.c0_rd_address <= bus.rd_ret_address;
            end
            if (rd_pop && rd_head) begin
                bus.c1_rd_data    <= bus.rd_ret_data;
                bus.c1_rd_address <= bus.rd_ret_address;
            end
            bus.c0_wr_ack <= wr_pop && !wr_head;
            bus.c1_wr_ack <= wr_pop && wr_head;

            // Acks with nothing outstanding are dropped but flagged until reset.
            if ((bus.rd_ret_ack && rd_cnt == '0) || (bus.wr_ret_ack && wr_cnt == '0))
                bus.err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, tag-FIFO full/wrap, return routing,
// orphan-ack error flag and asynchronous reset behaviour.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.OUTSTANDING(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.c0_req = 1'b0; bus.c1_req = 1'b0; bus.c0_we = 1'b0; bus.c1_we = 1'b0;
        bus.c0_address = '0; bus.c1_address = '0; bus.c0_data = '0; bus.c1_data = '0;
        bus.wr_ret_address = '0; bus.wr_ret_ack = 1'b0;
        bus.rd_ret_data = '0; bus.rd_ret_address = '0; bus.rd_ret_ack = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        bus.c0_req = 1'b1;
        tick();
        compared++; if (bus.c0_gnt !== 1'b0) begin mismatched++; $display("FAIL reset_gnt got %b want 0", bus.c0_gnt); end
        compared++; if ({bus.rd_en, bus.wr_en, bus.err, bus.c0_rd_valid, bus.c1_rd_valid, bus.c0_wr_ack, bus.c1_wr_ack} !== 7'b0) begin
            mismatched++; $display("FAIL reset_outputs got %b want 0", {bus.rd_en, bus.wr_en, bus.err, bus.c0_rd_valid, bus.c1_rd_valid, bus.c0_wr_ack, bus.c1_wr_ack}); end
        compared++; if ({bus.rd_address, bus.wr_address, bus.wr_data} !== 48'h0) begin
            mismatched++; $display("FAIL reset_buses got %h want 0", {bus.rd_address, bus.wr_address, bus.wr_data}); end
        rst_n = 1'b1;
        bus.c0_address = 16'h0077;
        #1;
        compared++; if (bus.c0_gnt !== 1'b1) begin mismatched++; $display("FAIL first_edge_gnt got %b want 1", bus.c0_gnt); end
        tick();
        bus.c0_req = 1'b0;
        compared++; if (bus.rd_en !== 1'b1 || bus.rd_address !== 16'h0077) begin
            mismatched++; $display("FAIL first_edge_rd got en=%b addr=%h want en=1 addr=0077", bus.rd_en, bus.rd_address); end
    endtask

    task automatic test_two_reads;
        do_reset();
        bus.c0_req = 1'b1; bus.c0_address = 16'h0010;
        bus.c1_req = 1'b1; bus.c1_address = 16'h0020;
        #1;
        compared++; if ({bus.c0_gnt, bus.c1_gnt} !== 2'b10) begin mismatched++; $display("FAIL rr_cycle1 got c0/c1=%b want 10", {bus.c0_gnt, bus.c1_gnt}); end
        tick();
        compared++; if (bus.rd_en !== 1'b1 || bus.rd_address !== 16'h0010) begin
            mismatched++; $display("FAIL rr_issue1 got en=%b addr=%h want en=1 addr=0010", bus.rd_en, bus.rd_address); end
        #1;
        compared++; if ({bus.c0_gnt, bus.c1_gnt} !== 2'b01) begin mismatched++; $display("FAIL rr_cycle2 got c0/c1=%b want 01", {bus.c0_gnt, bus.c1_gnt}); end
        tick();
        bus.c0_req = 1'b0; bus.c1_req = 1'b0;
        bus.rd_ret_ack = 1'b1; bus.rd_ret_data = 16'hAAAA; bus.rd_ret_address = 16'h0010;
        compared++; if (bus.rd_en !== 1'b1 || bus.rd_address !== 16'h0020 || bus.wr_en !== 1'b0) begin
            mismatched++; $display("FAIL rr_issue2 got en=%b addr=%h wr_en=%b want en=1 addr=0020 wr_en=0", bus.rd_en, bus.rd_address, bus.wr_en); end
        tick();
        bus.rd_ret_data = 16'hBBBB; bus.rd_ret_address = 16'h0020;
        compared++; if (bus.rd_en !== 1'b0) begin mismatched++; $display("FAIL rr_rd_en_drop got %b want 0", bus.rd_en); end
        compared++; if ({bus.c0_rd_valid, bus.c1_rd_valid} !== 2'b10 || bus.c0_rd_data !== 16'hAAAA || bus.c0_rd_address !== 16'h0010) begin
            mismatched++; $display("FAIL rr_ret_c0 got v=%b data=%h addr=%h want v=10 data=aaaa addr=0010", {bus.c0_rd_valid, bus.c1_rd_valid}, bus.c0_rd_data, bus.c0_rd_address); end
        tick();
        bus.rd_ret_ack = 1'b0;
        compared++; if ({bus.c0_rd_valid, bus.c1_rd_valid} !== 2'b01 || bus.c1_rd_data !== 16'hBBBB || bus.c1_rd_address !== 16'h0020) begin
            mismatched++; $display("FAIL rr_ret_c1 got v=%b data=%h addr=%h want v=01 data=bbbb addr=0020", {bus.c0_rd_valid, bus.c1_rd_valid}, bus.c1_rd_data, bus.c1_rd_address); end
        compared++; if (bus.c0_rd_data !== 16'hAAAA || bus.c0_rd_address !== 16'h0010) begin
            mismatched++; $display("FAIL rr_c0_hold got data=%h addr=%h want aaaa/0010", bus.c0_rd_data, bus.c0_rd_address); end
        tick();
        compared++; if ({bus.c0_rd_valid, bus.c1_rd_valid, bus.err} !== 3'b000) begin
            mismatched++; $display("FAIL rr_quiet got %b want 000", {bus.c0_rd_valid, bus.c1_rd_valid, bus.err}); end
    endtask

    task automatic test_fifo_full;
        do_reset();
        bus.c0_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.c0_address = 16'h0100 + 16'(i);
            #1;
            compared++; if (bus.c0_gnt !== 1'b1) begin mismatched++; $display("FAIL full_fill%0d got gnt=%b want 1", i, bus.c0_gnt); end
            tick();
        end
        bus.c0_address = 16'h0104;
        bus.c1_req = 1'b1; bus.c1_we = 1'b1; bus.c1_address = 16'h5A5A; bus.c1_data = 16'h1234;
        #1;
        compared++; if ({bus.c0_gnt, bus.c1_gnt} !== 2'b01) begin mismatched++; $display("FAIL full_stall_write got c0/c1=%b want 01", {bus.c0_gnt, bus.c1_gnt}); end
        compared++; if (bus.rd_en !== 1'b1 || bus.rd_address !== 16'h0103) begin
            mismatched++; $display("FAIL full_last_rd got en=%b addr=%h want 1/0103", bus.rd_en, bus.rd_address); end
        tick();
        bus.c1_req = 1'b0; bus.c1_we = 1'b0;
        compared++; if (bus.wr_en !== 1'b1 || bus.rd_en !== 1'b0 || bus.wr_address !== 16'h5A5A || bus.wr_data !== 16'h1234) begin
            mismatched++; $display("FAIL full_wr_issue got wr_en=%b rd_en=%b addr=%h data=%h want 1/0/5a5a/1234", bus.wr_en, bus.rd_en, bus.wr_address, bus.wr_data); end
        bus.rd_ret_ack = 1'b1; bus.rd_ret_data = 16'hD00D; bus.rd_ret_address = 16'h0100;
        #1;
        compared++; if (bus.c0_gnt !== 1'b1) begin mismatched++; $display("FAIL full_pop_gnt got %b want 1", bus.c0_gnt); end
        tick();
        bus.rd_ret_ack = 1'b0;
        bus.c0_address = 16'h0105;
        compared++; if (bus.rd_en !== 1'b1 || bus.rd_address !== 16'h0104 || bus.wr_en !== 1'b0) begin
            mismatched++; $display("FAIL full_fifth_issue got en=%b addr=%h wr_en=%b want 1/0104/0", bus.rd_en, bus.rd_address, bus.wr_en); end
        compared++; if (bus.c0_rd_valid !== 1'b1 || bus.c0_rd_data !== 16'hD00D || bus.c0_rd_address !== 16'h0100) begin
            mismatched++; $display("FAIL full_ret got v=%b data=%h addr=%h want 1/d00d/0100", bus.c0_rd_valid, bus.c0_rd_data, bus.c0_rd_address); end
        #1;
        compared++; if (bus.c0_gnt !== 1'b0) begin mismatched++; $display("FAIL full_still_full got %b want 0", bus.c0_gnt); end
        bus.c0_req = 1'b0;
        bus.wr_ret_ack = 1'b1; bus.wr_ret_address = 16'h5A5A;
        tick();
        bus.wr_ret_ack = 1'b0;
        compared++; if ({bus.c0_wr_ack, bus.c1_wr_ack} !== 2'b01) begin mismatched++; $display("FAIL full_wr_ack got c0/c1=%b want 01", {bus.c0_wr_ack, bus.c1_wr_ack}); end
        tick();
        compared++; if ({bus.c0_wr_ack, bus.c1_wr_ack, bus.err} !== 3'b000) begin
            mismatched++; $display("FAIL full_wr_ack_pulse got %b want 000", {bus.c0_wr_ack, bus.c1_wr_ack, bus.err}); end
    endtask

    task automatic test_orphan_ack;
        do_reset();
        bus.wr_ret_ack = 1'b1;
        tick();
        bus.wr_ret_ack = 1'b0;
        compared++; if ({bus.c0_wr_ack, bus.c1_wr_ack} !== 2'b00) begin mismatched++; $display("FAIL orphan_no_ack got %b want 00", {bus.c0_wr_ack, bus.c1_wr_ack}); end
        compared++; if (bus.err !== 1'b1) begin mismatched++; $display("FAIL orphan_err got %b want 1", bus.err); end
        tick(); tick(); tick();
        compared++; if (bus.err !== 1'b1) begin mismatched++; $display("FAIL orphan_err_sticky got %b want 1", bus.err); end
        rst_n = 1'b0;
        #1;
        compared++; if (bus.err !== 1'b0) begin mismatched++; $display("FAIL orphan_err_clear got %b want 0", bus.err); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.c0_req = 1'b1; bus.c0_address = 16'h0040;
        tick();
        bus.c0_req = 1'b0; bus.c1_req = 1'b1; bus.c1_address = 16'h0041;
        tick();
        bus.c1_req = 1'b0; bus.c0_req = 1'b1; bus.c0_address = 16'h0042;
        tick();
        bus.c0_req = 1'b0;
        compared++; if (bus.rd_en !== 1'b1 || bus.rd_address !== 16'h0042) begin
            mismatched++; $display("FAIL mid_third_rd got en=%b addr=%h want 1/0042", bus.rd_en, bus.rd_address); end
        #2;
        rst_n = 1'b0;
        #1;
        compared++; if (bus.rd_en !== 1'b0 || bus.rd_address !== 16'h0000 || bus.c0_gnt !== 1'b0 || bus.err !== 1'b0) begin
            mismatched++; $display("FAIL mid_async_clear got en=%b addr=%h gnt=%b err=%b want all 0", bus.rd_en, bus.rd_address, bus.c0_gnt, bus.err); end
        tick();
        rst_n = 1'b1;
        tick();
        bus.rd_ret_ack = 1'b1; bus.rd_ret_data = 16'hBEEF; bus.rd_ret_address = 16'h0040;
        tick();
        bus.rd_ret_ack = 1'b0;
        compared++; if ({bus.c0_rd_valid, bus.c1_rd_valid} !== 2'b00 || bus.c0_rd_data !== 16'h0000) begin
            mismatched++; $display("FAIL mid_discard got v=%b data=%h want 00/0000", {bus.c0_rd_valid, bus.c1_rd_valid}, bus.c0_rd_data); end
        compared++; if (bus.err !== 1'b1) begin mismatched++; $display("FAIL mid_err got %b want 1", bus.err); end
    endtask

    task automatic test_wrap;
        logic [15:0] a;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            a = 16'h0300 + 16'(i);
            if (i % 2 == 0) begin bus.c0_req = 1'b1; bus.c0_address = a; end
            else            begin bus.c1_req = 1'b1; bus.c1_address = a; end
            #1;
            compared++; if ({bus.c0_gnt, bus.c1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                mismatched++; $display("FAIL wrap_gnt%0d got c0/c1=%b", i, {bus.c0_gnt, bus.c1_gnt}); end
            tick();
            bus.c0_req = 1'b0; bus.c1_req = 1'b0;
            compared++; if (bus.rd_en !== 1'b1 || bus.rd_address !== a) begin
                mismatched++; $display("FAIL wrap_issue%0d got en=%b addr=%h want 1/%h", i, bus.rd_en, bus.rd_address, a); end
            bus.rd_ret_ack = 1'b1; bus.rd_ret_address = a; bus.rd_ret_data = ~a;
            tick();
            bus.rd_ret_ack = 1'b0;
            if (i % 2 == 0) begin
                compared++; if ({bus.c0_rd_valid, bus.c1_rd_valid} !== 2'b10 || bus.c0_rd_address !== a || bus.c0_rd_data !== ~a) begin
                    mismatched++; $display("FAIL wrap_ret%0d got v=%b addr=%h data=%h want 10/%h/%h", i, {bus.c0_rd_valid, bus.c1_rd_valid}, bus.c0_rd_address, bus.c0_rd_data, a, ~a); end
            end else begin
                compared++; if ({bus.c0_rd_valid, bus.c1_rd_valid} !== 2'b01 || bus.c1_rd_address !== a || bus.c1_rd_data !== ~a) begin
                    mismatched++; $display("FAIL wrap_ret%0d got v=%b addr=%h data=%h want 01/%h/%h", i, {bus.c0_rd_valid, bus.c1_rd_valid}, bus.c1_rd_address, bus.c1_rd_data, a, ~a); end
            end
        end
        compared++; if (bus.err !== 1'b0) begin mismatched++; $display("FAIL wrap_err got %b want 0", bus.err); end
    endtask

    initial begin
        test_reset();
        test_two_reads();
        test_fifo_full();
        test_orphan_ack();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
